// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for bus_arbiter and its optional fetch buffer.
package bus_arbiter_pkg;

   localparam int unsigned BA_ADDR_W = 32;
   localparam int unsigned BA_DATA_W = 32;
   localparam logic [BA_ADDR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      MEM   = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [BA_ADDR_W-1:0] address;
      logic [BA_DATA_W-1:0] data;
      logic [3:0]           strobe;
      logic                 write;
      logic                 instruction;
   } req_t;

   function automatic logic [BA_ADDR_W-1:0] word_addr(input logic [BA_ADDR_W-1:0] a);
      return a & WORD_MASK;
   endfunction

endpackage

// File: rtl/bus_arbiter_fetch_buffer.sv
// One-entry instruction buffer (tag, data, valid); only built when
// BUS_ARBITER_FETCH_BUFFER_EN is defined.
`ifdef BUS_ARBITER_FETCH_BUFFER_EN
module fetch_buffer
   import bus_arbiter_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fill_i,
   input  logic [BA_ADDR_W-1:0] fill_addr_i,
   input  logic [BA_DATA_W-1:0] fill_data_i,
   input  logic                 inval_i,
   input  logic [BA_ADDR_W-1:0] inval_addr_i,
   input  logic [BA_ADDR_W-1:0] lookup_addr_i,
   output logic                 hit_o,
   output logic [BA_DATA_W-1:0] data_o
);

   logic [BA_ADDR_W-1:0] tag_q;
   logic [BA_DATA_W-1:0] data_q;
   logic                 valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (fill_i) begin
         tag_q   <= word_addr(fill_addr_i);
         data_q  <= fill_data_i;
         valid_q <= 1'b1;
      end else if (inval_i && (word_addr(inval_addr_i) == tag_q)) begin
         valid_q <= 1'b0;
      end
   end

   assign hit_o  = valid_q && (tag_q == word_addr(lookup_addr_i));
   assign data_o = data_q;

endmodule
`endif

// File: rtl/bus_arbiter.sv
// Serialises instruction fetch and load/store onto one external bus, memory first.
// Optional one-entry fetch buffer enabled by BUS_ARBITER_FETCH_BUFFER_EN.
//
// state | meaning
// IDLE  | no bus op; pick memory request, else fetch
// FETCH | fetch op on bus, waiting for ext_ready
// MEM   | load or store on bus, waiting for ext_ready
// DONE  | one-cycle response to the original requester
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] fetch_address,
   output logic [DATA_WIDTH-1:0] fetch_data,
   output logic                  fetch_ready,
   input  logic [ADDR_WIDTH-1:0] mem_address,
   input  logic [DATA_WIDTH-1:0] mem_store_data,
   input  logic [3:0]            mem_byte_enable,
   input  logic                  mem_read,
   input  logic                  mem_write,
   output logic [DATA_WIDTH-1:0] mem_load_data,
   output logic                  mem_ready,
   output logic                  ext_valid,
   input  logic                  ext_ready,
   output logic                  ext_write,
   output logic                  ext_instruction,
   output logic [ADDR_WIDTH-1:0] ext_address,
   output logic [DATA_WIDTH-1:0] ext_write_data,
   output logic [3:0]            ext_write_strobe,
   input  logic [DATA_WIDTH-1:0] ext_read_data
);

   state_e                state_q, state_d;
   req_t                  req_q, req_d;
   logic                  ext_valid_q, ext_valid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  mem_req;
   logic                  buf_hit;
   logic [DATA_WIDTH-1:0] buf_data;

   assign mem_req = mem_read | mem_write;

`ifdef BUS_ARBITER_FETCH_BUFFER_EN
   logic buf_lookup_hit;

   fetch_buffer u_fetch_buffer (
      .clk           (clk),
      .reset         (reset),
      .fill_i        ((state_q == FETCH) && ext_ready),
      .fill_addr_i   (req_q.address),
      .fill_data_i   (ext_read_data),
      .inval_i       ((state_q == IDLE) && mem_write),
      .inval_addr_i  (mem_address),
      .lookup_addr_i (fetch_address),
      .hit_o         (buf_lookup_hit),
      .data_o        (buf_data)
   );

   assign buf_hit = (state_q == IDLE) && buf_lookup_hit;
`else
   assign buf_hit  = 1'b0;
   assign buf_data = '0;
`endif

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      ext_valid_d = ext_valid_q;
      rdata_d     = rdata_q;
      unique case (state_q)
         IDLE: begin
            // A both-read-and-write request is treated as a write.
            if (mem_req) begin
               req_d.address     = mem_address;
               req_d.data        = mem_write ? mem_store_data : '0;
               req_d.strobe      = mem_write ? mem_byte_enable : 4'b0000;
               req_d.write       = mem_write;
               req_d.instruction = 1'b0;
               ext_valid_d       = 1'b1;
               state_d           = MEM;
            end else if (!buf_hit) begin
               req_d.address     = fetch_address;
               req_d.data        = '0;
               req_d.strobe      = 4'b0000;
               req_d.write       = 1'b0;
               req_d.instruction = 1'b1;
               ext_valid_d       = 1'b1;
               state_d           = FETCH;
            end
         end
         FETCH, MEM: begin
            if (ext_ready) begin
               rdata_d     = ext_read_data;
               ext_valid_d = 1'b0;
               state_d     = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         req_q       <= '0;
         ext_valid_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         ext_valid_q <= ext_valid_d;
         rdata_q     <= rdata_d;
      end
   end

   assign ext_valid        = ext_valid_q;
   assign ext_write        = req_q.write;
   assign ext_instruction  = req_q.instruction;
   assign ext_address      = word_addr(req_q.address);
   assign ext_write_data   = req_q.data;
   assign ext_write_strobe = req_q.strobe;

   // Results of a redirected fetch or withdrawn memory op are dropped here.
   assign fetch_ready   = buf_hit ||
                          ((state_q == DONE) && req_q.instruction && (req_q.address == fetch_address));
   assign fetch_data    = buf_hit ? buf_data : rdata_q;
   assign mem_ready     = !mem_req ||
                          ((state_q == DONE) && !req_q.instruction && (req_q.address == mem_address));
   assign mem_load_data = rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// fetch/load/store traffic against a word-memory reference model.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fetch_address, fetch_data;
   logic        fetch_ready;
   logic [31:0] mem_address, mem_store_data, mem_load_data;
   logic [3:0]  mem_byte_enable;
   logic        mem_read, mem_write, mem_ready;
   logic        ext_valid, ext_ready, ext_write, ext_instruction;
   logic [31:0] ext_address, ext_write_data, ext_read_data;
   logic [3:0]  ext_write_strobe;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int bus_waits = 0;
   int wait_cnt  = 0;

   logic [31:0] bus_mem   [logic [31:0]];
   logic [31:0] model_mem [logic [31:0]];
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_strobe;
   logic        last_write;

   bus_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .fetch_address    (fetch_address),
      .fetch_data       (fetch_data),
      .fetch_ready      (fetch_ready),
      .mem_address      (mem_address),
      .mem_store_data   (mem_store_data),
      .mem_byte_enable  (mem_byte_enable),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .mem_load_data    (mem_load_data),
      .mem_ready        (mem_ready),
      .ext_valid        (ext_valid),
      .ext_ready        (ext_ready),
      .ext_write        (ext_write),
      .ext_instruction  (ext_instruction),
      .ext_address      (ext_address),
      .ext_write_data   (ext_write_data),
      .ext_write_strobe (ext_write_strobe),
      .ext_read_data    (ext_read_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   function automatic logic [31:0] bus_get(input logic [31:0] a);
      if (bus_mem.exists(a)) return bus_mem[a];
      return init_word(a);
   endfunction

   function automatic logic [31:0] model_get(input logic [31:0] a);
      if (model_mem.exists(a)) return model_mem[a];
      return init_word(a);
   endfunction

   // External bus: ready after bus_waits wait cycles, backed by bus_mem.
   initial begin
      logic [31:0] w;
      ext_ready     = 1'b0;
      ext_read_data = '0;
      forever begin
         @(negedge clk);
         if (ext_valid === 1'b1) begin
            if (wait_cnt >= bus_waits) begin
               wait_cnt      = 0;
               ext_ready     = 1'b1;
               w             = bus_get(ext_address);
               ext_read_data = w;
               if (ext_write) begin
                  for (int b = 0; b < 4; b++)
                     if (ext_write_strobe[b]) w[8*b +: 8] = ext_write_data[8*b +: 8];
                  bus_mem[ext_address] = w;
               end
               last_addr   = ext_address;
               last_write  = ext_write;
               last_strobe = ext_write_strobe;
               last_wdata  = ext_write_data;
            end else begin
               ext_ready = 1'b0;
               wait_cnt++;
            end
         end else begin
            ext_ready = 1'b0;
            wait_cnt  = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Holds reset for two cycles, then releases it at a negedge with the given
   // requests applied; the cycle that follows is the first arbitration cycle.
   task automatic do_reset(input logic [31:0] fa, input logic rd, input logic wr,
                           input logic [31:0] ma, input logic [31:0] sd,
                           input logic [3:0] be, input int waits);
      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      bus_waits = waits;
      repeat (2) @(negedge clk);
      fetch_address = fa; mem_read = rd; mem_write = wr;
      mem_address = ma; mem_store_data = sd; mem_byte_enable = be;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      fetch_address = 32'h100; mem_address = '0; mem_store_data = '0; mem_byte_enable = '0;
      repeat (3) @(negedge clk);
      total_cnt++; if (ext_valid !== 1'b0) $display("FAIL rst_ext_valid got %b exp 0", ext_valid); else pass_cnt++;
      total_cnt++; if (ext_write !== 1'b0) $display("FAIL rst_ext_write got %b exp 0", ext_write); else pass_cnt++;
      total_cnt++; if (ext_instruction !== 1'b0) $display("FAIL rst_ext_instr got %b exp 0", ext_instruction); else pass_cnt++;
      total_cnt++; if (ext_write_strobe !== 4'h0) $display("FAIL rst_strobe got %h exp 0", ext_write_strobe); else pass_cnt++;
      total_cnt++; if (ext_address !== 32'h0) $display("FAIL rst_ext_address got %h exp 0", ext_address); else pass_cnt++;
      total_cnt++; if (ext_write_data !== 32'h0) $display("FAIL rst_ext_wdata got %h exp 0", ext_write_data); else pass_cnt++;
      total_cnt++; if (fetch_ready !== 1'b0) $display("FAIL rst_fetch_ready got %b exp 0", fetch_ready); else pass_cnt++;
      total_cnt++; if (fetch_data !== 32'h0) $display("FAIL rst_fetch_data got %h exp 0", fetch_data); else pass_cnt++;
      total_cnt++; if (mem_load_data !== 32'h0) $display("FAIL rst_load_data got %h exp 0", mem_load_data); else pass_cnt++;
      total_cnt++; if (mem_ready !== 1'b1) $display("FAIL rst_mem_ready got %b exp 1", mem_ready); else pass_cnt++;
   endtask

   task automatic test_fetch_basic();
      bus_mem[32'h100] = 32'h0000_0013;
      do_reset(32'h100, 1'b0, 1'b0, '0, '0, '0, 0);
      @(negedge clk);
      total_cnt++;
      if ({ext_valid, ext_instruction, ext_write, ext_address} !== {3'b110, 32'h100})
         $display("FAIL fetch_c1_bus got v%b i%b w%b a%h exp v1 i1 w0 a00000100",
                  ext_valid, ext_instruction, ext_write, ext_address);
      else pass_cnt++;
      total_cnt++; if (fetch_ready !== 1'b0) $display("FAIL fetch_c1_ready got %b exp 0", fetch_ready); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (fetch_ready !== 1'b1) $display("FAIL fetch_c2_ready got %b exp 1", fetch_ready); else pass_cnt++;
      total_cnt++; if (fetch_data !== 32'h13) $display("FAIL fetch_c2_data got %h exp 00000013", fetch_data); else pass_cnt++;
      total_cnt++; if (ext_valid !== 1'b0) $display("FAIL fetch_c2_valid got %b exp 0", ext_valid); else pass_cnt++;
   endtask

   task automatic test_priority();
      bus_mem[32'h1004] = 32'hDEAD_BEEF;
      bus_mem[32'h200]  = 32'h00A0_0093;
      do_reset(32'h200, 1'b1, 1'b0, 32'h1004, '0, '0, 0);
      @(negedge clk);
      total_cnt++;
      if ({ext_valid, ext_instruction, ext_write, ext_write_strobe, ext_address} !== {3'b100, 4'h0, 32'h1004})
         $display("FAIL prio_c1_bus got v%b i%b w%b s%h a%h exp v1 i0 w0 s0 a00001004",
                  ext_valid, ext_instruction, ext_write, ext_write_strobe, ext_address);
      else pass_cnt++;
      total_cnt++; if (mem_ready !== 1'b0) $display("FAIL prio_c1_mem_ready got %b exp 0", mem_ready); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (mem_ready !== 1'b1) $display("FAIL prio_c2_mem_ready got %b exp 1", mem_ready); else pass_cnt++;
      total_cnt++; if (mem_load_data !== 32'hDEAD_BEEF) $display("FAIL prio_c2_load got %h exp deadbeef", mem_load_data); else pass_cnt++;
      total_cnt++; if (fetch_ready !== 1'b0) $display("FAIL prio_c2_fetch_ready got %b exp 0", fetch_ready); else pass_cnt++;
      mem_read = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({ext_valid, fetch_ready} !== 2'b00) $display("FAIL prio_c3_idle got v%b r%b exp v0 r0", ext_valid, fetch_ready);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({ext_valid, ext_instruction, ext_address, fetch_ready} !== {2'b11, 32'h200, 1'b0})
         $display("FAIL prio_c4_fetch got v%b i%b a%h r%b exp v1 i1 a00000200 r0",
                  ext_valid, ext_instruction, ext_address, fetch_ready);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({fetch_ready, fetch_data} !== {1'b1, 32'h00A0_0093})
         $display("FAIL prio_c5_fetch got r%b d%h exp r1 d00a00093", fetch_ready, fetch_data);
      else pass_cnt++;
   endtask

   task automatic test_store_wait();
      bus_mem[32'h1000] = 32'h1122_3344;
      do_reset(32'h300, 1'b0, 1'b1, 32'h1003, 32'hAB00_0000, 4'b1000, 3);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         total_cnt++;
         if ({ext_valid, ext_write, ext_instruction, ext_write_strobe, ext_address, ext_write_data, mem_ready}
             !== {3'b110, 4'b1000, 32'h1000, 32'hAB00_0000, 1'b0})
            $display("FAIL store_wait_c%0d got v%b w%b i%b s%h a%h d%h r%b exp v1 w1 i0 s8 a00001000 dab000000 r0",
                     c, ext_valid, ext_write, ext_instruction, ext_write_strobe, ext_address, ext_write_data, mem_ready);
         else pass_cnt++;
      end
      @(negedge clk);
      total_cnt++;
      if ({mem_ready, ext_valid} !== 2'b10) $display("FAIL store_done got r%b v%b exp r1 v0", mem_ready, ext_valid);
      else pass_cnt++;
      mem_write = 1'b0;
      total_cnt++;
      if (bus_get(32'h1000) !== 32'hAB22_3344) $display("FAIL store_merge got %h exp ab223344", bus_get(32'h1000));
      else pass_cnt++;
   endtask

   task automatic test_branch();
      bus_mem[32'h400] = 32'h0000_0067;
      do_reset(32'h100, 1'b0, 1'b0, '0, '0, '0, 2);
      @(negedge clk);
      fetch_address = 32'h400;
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk);
         total_cnt++;
         if ({ext_valid, ext_address, fetch_ready} !== {1'b1, 32'h100, 1'b0})
            $display("FAIL branch_c%0d got v%b a%h r%b exp v1 a00000100 r0", c, ext_valid, ext_address, fetch_ready);
         else pass_cnt++;
      end
      @(negedge clk);
      total_cnt++;
      if ({ext_valid, fetch_ready} !== 2'b00) $display("FAIL branch_drop got v%b r%b exp v0 r0", ext_valid, fetch_ready);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (fetch_ready !== 1'b0) $display("FAIL branch_idle got r%b exp r0", fetch_ready); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({ext_valid, ext_instruction, ext_address} !== {2'b11, 32'h400})
         $display("FAIL branch_refetch got v%b i%b a%h exp v1 i1 a00000400", ext_valid, ext_instruction, ext_address);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({fetch_ready, fetch_data} !== {1'b1, 32'h67})
         $display("FAIL branch_done got r%b d%h exp r1 d00000067", fetch_ready, fetch_data);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_op();
      do_reset(32'h100, 1'b1, 1'b0, 32'h1004, '0, '0, 10);
      @(negedge clk);
      total_cnt++;
      if ({ext_valid, ext_instruction} !== 2'b10) $display("FAIL rmid_c1 got v%b i%b exp v1 i0", ext_valid, ext_instruction);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({ext_valid, ext_address, mem_ready} !== {1'b0, 32'h0, 1'b0})
         $display("FAIL rmid_drop got v%b a%h r%b exp v0 a00000000 r0", ext_valid, ext_address, mem_ready);
      else pass_cnt++;
      reset = 1'b0; mem_read = 1'b0; fetch_address = 32'h100; bus_waits = 0;
      @(negedge clk);
      total_cnt++;
      if ({ext_valid, ext_instruction, ext_address} !== {2'b11, 32'h100})
         $display("FAIL rmid_restart got v%b i%b a%h exp v1 i1 a00000100", ext_valid, ext_instruction, ext_address);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({fetch_ready, fetch_data} !== {1'b1, 32'h13})
         $display("FAIL rmid_fetch got r%b d%h exp r1 d00000013", fetch_ready, fetch_data);
      else pass_cnt++;
   endtask

`ifdef BUS_ARBITER_FETCH_BUFFER_EN
   task automatic test_fetch_buffer();
      bus_mem[32'h100] = 32'h0000_0013;
      do_reset(32'h100, 1'b0, 1'b0, '0, '0, '0, 0);
      repeat (2) @(negedge clk);
      for (int c = 3; c <= 4; c++) begin
         @(negedge clk);
         total_cnt++;
         if ({fetch_ready, fetch_data, ext_valid} !== {1'b1, 32'h13, 1'b0})
            $display("FAIL fbuf_hit_c%0d got r%b d%h v%b exp r1 d00000013 v0", c, fetch_ready, fetch_data, ext_valid);
         else pass_cnt++;
      end
      mem_write = 1'b1; mem_address = 32'h100; mem_store_data = 32'h73; mem_byte_enable = 4'hF;
      repeat (2) @(negedge clk);
      total_cnt++; if (mem_ready !== 1'b1) $display("FAIL fbuf_store got r%b exp r1", mem_ready); else pass_cnt++;
      mem_write = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({fetch_ready, ext_valid} !== 2'b00) $display("FAIL fbuf_inval got r%b v%b exp r0 v0", fetch_ready, ext_valid);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({ext_valid, ext_instruction, ext_address} !== {2'b11, 32'h100})
         $display("FAIL fbuf_refetch got v%b i%b a%h exp v1 i1 a00000100", ext_valid, ext_instruction, ext_address);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({fetch_ready, fetch_data} !== {1'b1, 32'h73})
         $display("FAIL fbuf_newdata got r%b d%h exp r1 d00000073", fetch_ready, fetch_data);
      else pass_cnt++;
   endtask
`endif

   task automatic test_random();
      logic [31:0] a, d, exp_w, waddr;
      logic [3:0]  be;
      int          kind;
      bit          seen;
      bus_mem.delete();
      model_mem.delete();
      do_reset(32'h100, 1'b0, 1'b0, '0, '0, '0, 0);
      for (int t = 0; t < 150; t++) begin
         kind      = $urandom_range(0, 2);
         bus_waits = $urandom_range(0, 3);
         a         = 32'h100 + ($urandom_range(0, 15) << 2);
         seen      = 1'b0;
         if (kind == 0) begin
            fetch_address = a; mem_read = 1'b0; mem_write = 1'b0;
            @(negedge clk);
            total_cnt++;
            if (mem_ready !== 1'b1) $display("FAIL rnd_idle_mem_ready t%0d got %b exp 1", t, mem_ready);
            else pass_cnt++;
            for (int c = 0; c < 40; c++) begin
               if (fetch_ready === 1'b1) begin seen = 1'b1; break; end
               @(negedge clk);
            end
            total_cnt++;
            if (!seen) $display("FAIL rnd_fetch_timeout t%0d addr %h got no ready exp ready", t, a);
            else if (fetch_data !== model_get(a))
               $display("FAIL rnd_fetch_data t%0d addr %h got %h exp %h", t, a, fetch_data, model_get(a));
            else pass_cnt++;
         end else begin
            waddr          = a;
            mem_address    = a | 32'($urandom_range(0, 3));
            d              = $urandom;
            be             = 4'($urandom_range(1, 15));
            mem_store_data = d;
            mem_byte_enable = be;
            mem_write      = (kind == 2);
            mem_read       = (kind == 1) || ($urandom_range(0, 3) == 0);
            for (int c = 0; c < 40; c++) begin
               @(negedge clk);
               if (mem_ready === 1'b1) begin seen = 1'b1; break; end
            end
            total_cnt++;
            if (!seen) $display("FAIL rnd_mem_timeout t%0d addr %h got no ready exp ready", t, mem_address);
            else if (kind == 1) begin
               if (mem_load_data !== model_get(waddr))
                  $display("FAIL rnd_load_data t%0d addr %h got %h exp %h", t, waddr, mem_load_data, model_get(waddr));
               else pass_cnt++;
            end else begin
               if ({last_write, last_addr, last_strobe, last_wdata} !== {1'b1, waddr, be, d})
                  $display("FAIL rnd_store_bus t%0d got w%b a%h s%h d%h exp w1 a%h s%h d%h",
                           t, last_write, last_addr, last_strobe, last_wdata, waddr, be, d);
               else pass_cnt++;
               exp_w = model_get(waddr);
               for (int b = 0; b < 4; b++) if (be[b]) exp_w[8*b +: 8] = d[8*b +: 8];
               model_mem[waddr] = exp_w;
            end
            mem_read = 1'b0; mem_write = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch_basic();
      test_priority();
      test_store_wait();
      test_branch();
      test_reset_mid_op();
`ifdef BUS_ARBITER_FETCH_BUFFER_EN
      test_fetch_buffer();
`endif
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
